// File: rtl/keypad_scan_encoder_if.sv
// Keypad scan encoder bus: keypad pin side (col_n in, row_n out) plus the
// encoded key outputs consumed by display/control logic.
//   col_n     : keypad columns, active low, asynchronous to clk
//   row_n     : row drive, exactly one bit low at a time
//   key_code  : encoded key index, row*4+col
//   key_valid : one-cycle pulse per newly accepted press
//   key_down  : level, high while a debounced key is held
//   multi_key : high while the accepted frame had more than one key
// master = encoder side, slave = keypad/consumer side.
interface keypad_scan_encoder_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       multi_key;

  modport master (
    input  col_n,
    output row_n,
    output key_code,
    output key_valid,
    output key_down,
    output multi_key
  );

  modport slave (
    output col_n,
    input  row_n,
    input  key_code,
    input  key_valid,
    input  key_down,
    input  multi_key
  );
endinterface

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner and encoder with frame-based debounce.
// Drives one row low at a time, samples synchronized columns at the end of
// each row dwell, encodes a whole frame at the end of row 3, and debounces
// presses/releases over DEBOUNCE consecutive identical frames.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (synchronous release expected)
//   kp    : keypad_scan_encoder_if.master (col_n in; row_n, key_code,
//           key_valid, key_down, multi_key out)
module keypad_scan_encoder #(
  parameter int unsigned SCAN_DIV = 4,  // cycles per row, >= 4
  parameter int unsigned DEBOUNCE = 2   // identical frames to accept, >= 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  keypad_scan_encoder_if.master         kp
);

  localparam int unsigned DwW  = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
  localparam logic [DwW-1:0]  DwLast = DwW'(SCAN_DIV - 1);
  // cnt holds the number of frames already seen; the current frame is the
  // one that would bring it to DEBOUNCE.
  localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {StIdle, StDbPress, StPressed, StDbRel} state_e;

  logic [3:0]      col_s1_q, col_s2_q;
  logic [DwW-1:0]  dwell_q;
  logic [1:0]      row_idx_q;
  logic [15:0]     acc_q;

  state_e          state_q;
  logic [3:0]      cand_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      key_code_q;
  logic            key_valid_q;
  logic            key_down_q;
  logic            multi_q;

  logic            sample;
  logic            frame_end;
  logic [3:0]      row_hits;
  logic [15:0]     frame_mask;
  logic            frame_hit;
  logic            frame_multi;
  logic [3:0]      frame_code;

  assign sample    = (dwell_q == DwLast);
  assign frame_end = sample && (row_idx_q == 2'd3);
  assign row_hits  = ~col_s2_q;

  // Row 3 is folded in combinationally on the cycle the frame is evaluated.
  always_comb begin
    frame_mask  = acc_q | {row_hits, 12'h000};
    frame_hit   = |frame_mask;
    frame_multi = |(frame_mask & (frame_mask - 16'd1));
    frame_code  = 4'd0;
    // Descending scan so the lowest index wins.
    for (int i = 15; i >= 0; i--) begin
      if (frame_mask[i]) frame_code = 4'(i);
    end
  end

  // Column synchronizer, row scan and frame accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q  <= 4'hF;
      col_s2_q  <= 4'hF;
      dwell_q   <= '0;
      row_idx_q <= 2'd0;
      acc_q     <= '0;
    end else begin
      col_s1_q <= kp.col_n;
      col_s2_q <= col_s1_q;
      if (sample) begin
        dwell_q   <= '0;
        row_idx_q <= row_idx_q + 2'd1;
        if (frame_end) begin
          acc_q <= '0;
        end else begin
          acc_q[{row_idx_q, 2'b00} +: 4] <= row_hits;
        end
      end else begin
        dwell_q <= dwell_q + DwW'(1);
      end
    end
  end

  // Debounce FSM with registered outputs; advances once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (frame_end) begin
        unique case (state_q)
          StIdle: begin
            if (frame_hit) begin
              if (DEBOUNCE == 1) begin
                state_q     <= StPressed;
                key_code_q  <= frame_code;
                key_down_q  <= 1'b1;
                multi_q     <= frame_multi;
                key_valid_q <= 1'b1;
              end else begin
                state_q <= StDbPress;
                cand_q  <= frame_code;
                cnt_q   <= CntW'(1);
              end
            end
          end
          StDbPress: begin
            if (!frame_hit) begin
              state_q <= StIdle;
            end else if (frame_code != cand_q) begin
              cand_q <= frame_code;
              cnt_q  <= CntW'(1);
            end else if (cnt_q == DbLast) begin
              state_q     <= StPressed;
              key_code_q  <= cand_q;
              key_down_q  <= 1'b1;
              multi_q     <= frame_multi;
              key_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StPressed: begin
            if (frame_hit) begin
              multi_q <= frame_multi;
            end else if (DEBOUNCE == 1) begin
              state_q    <= StIdle;
              key_down_q <= 1'b0;
              multi_q    <= 1'b0;
            end else begin
              state_q <= StDbRel;
              cnt_q   <= CntW'(1);
            end
          end
          StDbRel: begin
            if (frame_hit) begin
              // Release bounce: resume the held key, no new event.
              state_q <= StPressed;
              multi_q <= frame_multi;
            end else if (cnt_q == DbLast) begin
              state_q    <= StIdle;
              key_down_q <= 1'b0;
              multi_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign kp.row_n     = ~(4'b0001 << row_idx_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_down  = key_down_q;
  assign kp.multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
module tb_keypad_scan_encoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] keys;
  logic [3:0]  col_model;

  keypad_scan_encoder_if kp ();

  keypad_scan_encoder #(
    .SCAN_DIV (4),
    .DEBOUNCE (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: key k pulls column k%4 low while row k/4 is driven low.
  always_comb begin
    col_model = 4'hF;
    for (int k = 0; k < 16; k++) begin
      if (keys[k] && kp.row_n[k / 4] == 1'b0) col_model[k % 4] = 1'b0;
    end
  end
  assign kp.col_n = col_model;

  typedef struct {
    logic [3:0] code;
    logic       multi;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Pulse log written only by the monitor, consumed by the test tasks.
  int         cyc = 0;
  int         pulse_wr = 0;
  int         pulse_rd = 0;
  logic [3:0] obs_code [64];
  logic       obs_multi[64];
  logic       obs_down [64];
  int         obs_cyc  [64];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (kp.key_valid === 1'b1 && pulse_wr < 64) begin
      obs_code[pulse_wr]  = kp.key_code;
      obs_multi[pulse_wr] = kp.multi_key;
      obs_down[pulse_wr]  = kp.key_down;
      obs_cyc[pulse_wr]   = cyc;
      pulse_wr++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got stuck, required finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_pulse(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (pulse_wr > pulse_rd) got = 1'b1;
    end
  endtask

  task automatic wait_frame_start();
    logic [3:0] prev;
    prev = kp.row_n;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (kp.row_n == 4'b1110 && prev == 4'b0111) break;
      prev = kp.row_n;
    end
  endtask

  task automatic wait_idle();
    keys = 16'h0000;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (kp.key_down == 1'b0) break;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    int base;
    rst_n = 1'b0;
    keys  = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({kp.row_n, kp.key_code, kp.key_valid, kp.key_down, kp.multi_key} !== 11'b1110_0000_000) begin
      errors++;
      $display("FAIL reset_outputs: got row_n=%b code=%0d valid=%b down=%b multi=%b, required 1110/0/0/0/0",
               kp.row_n, kp.key_code, kp.key_valid, kp.key_down, kp.multi_key);
    end
    rst_n = 1'b1;
    base = pulse_wr;
    for (int i = 0; i < 32; i++) begin
      logic [3:0] exp_row;
      exp_row = ~(4'b0001 << ((i / 4) % 4));
      checks++;
      if (kp.row_n !== exp_row) begin
        errors++;
        $display("FAIL row_scan[%0d]: got row_n=%b, required %b", i, kp.row_n, exp_row);
      end
      @(negedge clk);
    end
    repeat (68) @(negedge clk);
    checks++;
    if (pulse_wr != base) begin
      errors++;
      $display("FAIL reset_no_pulse: got %0d pulses, required 0", pulse_wr - base);
    end
    checks++;
    if ({kp.key_code, kp.key_down, kp.multi_key} !== 6'b0) begin
      errors++;
      $display("FAIL idle_outputs: got code=%0d down=%b multi=%b, required 0/0/0",
               kp.key_code, kp.key_down, kp.multi_key);
    end
  endtask

  task automatic test_single_press();
    int t0;
    bit got;
    exp_t e;
    keys = 16'h0200;
    t0 = cyc;
    exp_q.push_back('{code: 4'd9, multi: 1'b0});
    wait_pulse(60, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL single_pulse: got no pulse in 60 cycles, required one");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (obs_cyc[pulse_rd] - t0 > 51) begin
        errors++;
        $display("FAIL single_latency: got %0d cycles, required <= 51", obs_cyc[pulse_rd] - t0);
      end
      checks++;
      if (obs_code[pulse_rd] !== e.code || obs_multi[pulse_rd] !== e.multi || obs_down[pulse_rd] !== 1'b1) begin
        errors++;
        $display("FAIL single_event: got code=%0d multi=%b down=%b, required %0d/%b/1",
                 obs_code[pulse_rd], obs_multi[pulse_rd], obs_down[pulse_rd], e.code, e.multi);
      end
      pulse_rd++;
    end
    repeat (48) @(negedge clk);
    checks++;
    if (pulse_wr != pulse_rd) begin
      errors++;
      $display("FAIL single_held_extra: got %0d extra pulses, required 0", pulse_wr - pulse_rd);
      pulse_rd = pulse_wr;
    end
    checks++;
    if (kp.key_down !== 1'b1 || kp.key_code !== 4'd9 || kp.multi_key !== 1'b0) begin
      errors++;
      $display("FAIL single_held: got down=%b code=%0d multi=%b, required 1/9/0",
               kp.key_down, kp.key_code, kp.multi_key);
    end
  endtask

  task automatic test_release();
    int t0;
    int dt;
    bit fell;
    bit got;
    exp_t e;
    keys = 16'h0000;
    t0 = cyc;
    fell = 1'b0;
    dt = 0;
    for (int i = 0; i < 60 && !fell; i++) begin
      @(negedge clk);
      if (kp.key_down == 1'b0) begin
        fell = 1'b1;
        dt = cyc - t0;
      end
    end
    checks++;
    if (!fell || dt <= 16 || dt > 51) begin
      errors++;
      $display("FAIL release_timing: got fell=%b after %0d cycles, required fall in 17..51",
               fell, dt);
    end
    checks++;
    if (kp.key_code !== 4'd9 || pulse_wr != pulse_rd) begin
      errors++;
      $display("FAIL release_state: got code=%0d pulses=%0d, required code 9 and no pulse",
               kp.key_code, pulse_wr - pulse_rd);
      pulse_rd = pulse_wr;
    end
    repeat (20) @(negedge clk);
    keys = 16'h0001;
    exp_q.push_back('{code: 4'd0, multi: 1'b0});
    wait_pulse(60, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL key0_pulse: got no pulse, required one");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (obs_code[pulse_rd] !== e.code || obs_multi[pulse_rd] !== e.multi) begin
        errors++;
        $display("FAIL key0_event: got code=%0d multi=%b, required %0d/%b",
                 obs_code[pulse_rd], obs_multi[pulse_rd], e.code, e.multi);
      end
      pulse_rd++;
    end
    wait_idle();
  endtask

  task automatic test_bounce();
    int base;
    bit got;
    exp_t e;
    wait_idle();
    base = pulse_wr;
    wait_frame_start();
    keys = 16'h0200;
    repeat (16) @(negedge clk);
    keys = 16'h0000;
    repeat (16) @(negedge clk);
    keys = 16'h0200;
    repeat (16) @(negedge clk);
    checks++;
    if (pulse_wr != base) begin
      errors++;
      $display("FAIL bounce_early: got %0d pulses before 2 hit frames, required 0", pulse_wr - base);
      pulse_rd = pulse_wr;
    end
    exp_q.push_back('{code: 4'd9, multi: 1'b0});
    wait_pulse(20, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bounce_pulse: got no pulse after 2nd hit frame, required one");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (obs_code[pulse_rd] !== e.code || obs_multi[pulse_rd] !== e.multi) begin
        errors++;
        $display("FAIL bounce_event: got code=%0d multi=%b, required %0d/%b",
                 obs_code[pulse_rd], obs_multi[pulse_rd], e.code, e.multi);
      end
      pulse_rd++;
    end
    wait_idle();
  endtask

  task automatic test_multi_key();
    bit got;
    exp_t e;
    keys = (16'h1 << 5) | (16'h1 << 14);
    exp_q.push_back('{code: 4'd5, multi: 1'b1});
    wait_pulse(60, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL multi_pulse: got no pulse, required one");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (obs_code[pulse_rd] !== e.code || obs_multi[pulse_rd] !== e.multi) begin
        errors++;
        $display("FAIL multi_event: got code=%0d multi=%b, required %0d/%b",
                 obs_code[pulse_rd], obs_multi[pulse_rd], e.code, e.multi);
      end
      pulse_rd++;
    end
    repeat (16) @(negedge clk);
    keys = 16'h1 << 14;
    repeat (48) @(negedge clk);
    checks++;
    if (pulse_wr != pulse_rd) begin
      errors++;
      $display("FAIL multi_partial_release_pulse: got %0d pulses, required 0", pulse_wr - pulse_rd);
      pulse_rd = pulse_wr;
    end
    checks++;
    if (kp.key_code !== 4'd5 || kp.multi_key !== 1'b0 || kp.key_down !== 1'b1) begin
      errors++;
      $display("FAIL multi_partial_release: got code=%0d multi=%b down=%b, required 5/0/1",
               kp.key_code, kp.multi_key, kp.key_down);
    end
    wait_idle();
  endtask

  task automatic test_async_reset();
    int base;
    int t_rel;
    bit got;
    exp_t e;
    wait_idle();
    wait_frame_start();
    base = pulse_wr;
    keys = 16'h0200;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({kp.row_n, kp.key_code, kp.key_valid, kp.key_down, kp.multi_key} !== 11'b1110_0000_000) begin
      errors++;
      $display("FAIL async_reset_outputs: got row_n=%b code=%0d valid=%b down=%b multi=%b, required 1110/0/0/0/0",
               kp.row_n, kp.key_code, kp.key_valid, kp.key_down, kp.multi_key);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t_rel = cyc;
    checks++;
    if (pulse_wr != base) begin
      errors++;
      $display("FAIL async_reset_no_pulse: got %0d pulses, required 0", pulse_wr - base);
      pulse_rd = pulse_wr;
    end
    exp_q.push_back('{code: 4'd9, multi: 1'b0});
    wait_pulse(60, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL post_reset_pulse: got no pulse, required one");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (obs_cyc[pulse_rd] - t_rel < 28 || obs_cyc[pulse_rd] - t_rel > 36) begin
        errors++;
        $display("FAIL post_reset_latency: got %0d cycles, required about 2 frames (28..36)",
                 obs_cyc[pulse_rd] - t_rel);
      end
      checks++;
      if (obs_code[pulse_rd] !== e.code || obs_multi[pulse_rd] !== e.multi) begin
        errors++;
        $display("FAIL post_reset_event: got code=%0d multi=%b, required %0d/%b",
                 obs_code[pulse_rd], obs_multi[pulse_rd], e.code, e.multi);
      end
      pulse_rd++;
    end
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    keys  = 16'h0000;
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_multi_key();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0 || pulse_wr != pulse_rd) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected left, %0d unread pulses, required 0/0",
               exp_q.size(), pulse_wr - pulse_rd);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
